// File: rtl/pipe_pkg.sv
// Shared types for the pipeline skid buffer: state encoding and occupancy width.
package pipe_pkg;

  // 2'b11 is unused; the next-state logic steers it back to EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

  localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_skid_reg_dff_vec.sv
// Enabled register of WIDTH bits: asynchronous active-low reset to zero, loads d when enable is high.
module dff_vec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready skid buffer. in_ready is decoded from the state register only,
// so there is no combinational path from out_ready back to in_ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy,
  output skid_state_t      dbg_state
);

  // Handshake: a word moves on a rising clk edge when valid and ready are both high
  // on that side; push = in_valid & in_ready, pop = out_valid & out_ready.

  skid_state_t      state;
  skid_state_t      state_nxt;
  logic             push;
  logic             pop;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    skid_en   = 1'b0;
    main_d    = in_data;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_en   = 1'b1;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
          if (push && pop) begin
            main_en = 1'b1;
          end else if (push) begin
            skid_en   = 1'b1;
            state_nxt = FULL;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // The skid entry is older than anything upstream, so it refills main first.
          main_d = skid_q;
          if (pop) begin
            main_en   = 1'b1;
            state_nxt = BUSY;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    occupancy = '0;
    case (state)
      EMPTY: begin
        in_ready = 1'b1;
      end
      BUSY: begin
        out_valid = 1'b1;
        in_ready  = 1'b1;
        occupancy = 2'd1;
      end
      FULL: begin
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        out_valid = 1'b0;
        in_ready  = 1'b0;
        occupancy = '0;
      end
    endcase
  end

  assign dbg_state = state;

  dff_vec #(.WIDTH(WIDTH)) u_main (
    .clk    (clk),
    .reset  (reset),
    .enable (main_en),
    .d      (main_d),
    .q      (out_data)
  );

  dff_vec #(.WIDTH(WIDTH)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .enable (skid_en),
    .d      (in_data),
    .q      (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, reset/flush sequences, and random traffic vs a queue model.
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  skid_state_t  dbg_state;

  int total;
  int bad;

  pipe_skid_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         fl;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         e_ov;
    logic         e_ir;
    logic [1:0]   e_occ;
    logic [W-1:0] e_od;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic fl, logic iv, logic [W-1:0] d, logic ordy,
                              logic e_ov, logic e_ir, logic [1:0] e_occ, logic [W-1:0] e_od);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ; v.e_od = e_od;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [W-1:0] d, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  // scoreboard: entries the buffer should currently hold, oldest first
  logic [W-1:0] exp_q[$];

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);

    // expected after each edge: {ov, ir, occ, od}
    vecs[0]  = mk(0, 1, 32'h11, 1, 1, 1, 2'd1, 32'h11);
    vecs[1]  = mk(0, 1, 32'h22, 1, 1, 1, 2'd1, 32'h22);
    vecs[2]  = mk(0, 1, 32'h33, 1, 1, 1, 2'd1, 32'h33);
    vecs[3]  = mk(0, 0, 32'h0,  1, 0, 1, 2'd0, 32'h0);
    vecs[4]  = mk(0, 1, 32'hA0, 0, 1, 1, 2'd1, 32'hA0);
    vecs[5]  = mk(0, 1, 32'hB0, 0, 1, 0, 2'd2, 32'hA0);
    vecs[6]  = mk(0, 1, 32'hC0, 0, 1, 0, 2'd2, 32'hA0);
    vecs[7]  = mk(0, 1, 32'hC0, 1, 1, 1, 2'd1, 32'hB0);
    vecs[8]  = mk(0, 1, 32'hC0, 1, 1, 1, 2'd1, 32'hC0);
    vecs[9]  = mk(0, 0, 32'h0,  1, 0, 1, 2'd0, 32'h0);
    vecs[10] = mk(0, 1, 32'h55, 0, 1, 1, 2'd1, 32'h55);
    vecs[11] = mk(0, 1, 32'h66, 1, 1, 1, 2'd1, 32'h66);
    vecs[12] = mk(0, 0, 32'h0,  1, 0, 1, 2'd0, 32'h0);
    vecs[13] = mk(0, 1, 32'h01, 0, 1, 1, 2'd1, 32'h01);
    vecs[14] = mk(0, 1, 32'h02, 0, 1, 0, 2'd2, 32'h01);
    vecs[15] = mk(1, 0, 32'h0,  1, 0, 1, 2'd0, 32'h0);
    vecs[16] = mk(1, 1, 32'h77, 1, 0, 1, 2'd0, 32'h0);
    vecs[17] = mk(0, 0, 32'h0,  1, 0, 1, 2'd0, 32'h0);

    #12;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_in_ready",  {31'b0, in_ready},  32'd1);
    check("reset_occupancy", {30'b0, occupancy}, 32'd0);
    check("reset_out_data",  out_data,           32'd0);
    @(negedge clk);
    reset = 1'b1;

    // directed table
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
      check($sformatf("vec%0d_in_ready", i),  {31'b0, in_ready},  {31'b0, vecs[i].e_ir});
      check($sformatf("vec%0d_occupancy", i), {30'b0, occupancy}, {30'b0, vecs[i].e_occ});
      if (vecs[i].e_ov) check($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
    end

    // reset while FULL, checked with no clock edge in between
    @(negedge clk);
    drive(1'b0, 1'b1, 32'hAA, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'hBB, 1'b0);
    @(negedge clk);
    check("pre_reset_full_occ", {30'b0, occupancy}, 32'd2);
    #2 reset = 1'b0;
    #1;
    check("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_reset_in_ready",  {31'b0, in_ready},  32'd1);
    check("async_reset_occupancy", {30'b0, occupancy}, 32'd0);
    check("async_reset_out_data",  out_data,           32'd0);
    check("async_reset_state",     {30'b0, dbg_state}, {30'b0, EMPTY});
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0);
    reset = 1'b1;

    // random traffic against the queue model
    exp_q.delete();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      logic         fl, iv, ordy, m_push, m_pop, ir_a, ir_b;
      logic [W-1:0] d;
      @(negedge clk);
      check("rnd_out_valid", {31'b0, out_valid}, {31'b0, (exp_q.size() > 0)});
      check("rnd_in_ready",  {31'b0, in_ready},  {31'b0, (exp_q.size() < 2)});
      check("rnd_occupancy", {30'b0, occupancy}, exp_q.size());
      if (exp_q.size() > 0) check("rnd_out_data", out_data, exp_q[0]);
      fl   = ($urandom_range(0, 49) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      d    = $urandom;
      drive(fl, iv, d, ordy);
      #1 ir_a = in_ready;
      out_ready = ~ordy;
      #1 ir_b = in_ready;
      out_ready = ordy;
      check("rnd_in_ready_indep", {31'b0, ir_b}, {31'b0, ir_a});
      m_push = iv && (exp_q.size() < 2);
      m_pop  = ordy && (exp_q.size() > 0);
      @(posedge clk);
      if (fl) begin
        exp_q.delete();
      end else begin
        if (m_pop)  void'(exp_q.pop_front());
        if (m_push) exp_q.push_back(d);
      end
    end

    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
